// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-requester AHB arbiter.
package ahb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_if.sv
// AHB-side bus of the arbiter: the master modport drives address/data phase, the slave answers.
`include "const_defines.svh"

interface ahb_arbiter_if #(
    parameter int unsigned AW = `AHB_ADDR_WIDTH,
    parameter int unsigned DW = `AHB_DATA_WIDTH
);

    logic          hsel;
    logic          hwrite;
    logic [AW-1:0] haddr_m2s;
    logic [DW-1:0] hdata_m2s;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;

    modport master (
        output hsel,
        output hwrite,
        output haddr_m2s,
        output hdata_m2s,
        input  hready,
        input  hresp,
        input  hrdata
    );

    modport slave (
        input  hsel,
        input  hwrite,
        input  haddr_m2s,
        input  hdata_m2s,
        output hready,
        output hresp,
        output hrdata
    );

endinterface

// File: rtl/ahb_arb_pick.sv
// Winner select for two requesters: fixed priority (req0 first) by default,
// round-robin with a one-bit favour pointer when AHB_ARB_RR_EN is defined.
module ahb_arb_pick
    import ahb_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    input  logic               grant,
    output logic               win,
    output logic               any_valid
);

    assign any_valid = |valid;

`ifdef AHB_ARB_RR_EN
    logic ptr;

    // Pointer moves away from whoever was just served, so a tie alternates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant;
        end
    end

    always_comb begin
        win = 1'b0;
        if (valid[0] && valid[1]) begin
            win = ptr;
        end else if (valid[1]) begin
            win = 1'b1;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rstn, advance, grant};

    always_comb begin
        win = 1'b0;
        if (!valid[0] && valid[1]) begin
            win = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/const_defines.svh
// Codebase-wide AHB bus widths shared by the arbiter slice and its bus interface.
`ifndef CONST_DEFINES_SVH
`define CONST_DEFINES_SVH

`define AHB_ADDR_WIDTH 32
`define AHB_DATA_WIDTH 32

`endif

// File: rtl/ahb_arbiter.sv
// Two-requester, single-outstanding AHB master arbiter (IDLE/ADDR/DATA/RESP).
// Define AHB_ARB_RR_EN for round-robin arbitration instead of fixed priority.
`include "const_defines.svh"

module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned AW = `AHB_ADDR_WIDTH,
    parameter int unsigned DW = `AHB_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            req0_valid,
    input  logic            req0_write,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_wdata,
    output logic            req0_done,

    input  logic            req1_valid,
    input  logic            req1_write,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_wdata,
    output logic            req1_done,

    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,

    ahb_arbiter_if.master   bus
);

    arb_state_e         state;
    arb_state_e         state_nxt;

    logic               lat_write;
    logic [AW-1:0]      lat_addr;
    logic [DW-1:0]      lat_wdata;
    logic               grant;

    logic [NUM_REQ-1:0] valid;
    logic               win;
    logic               any_valid;
    logic               take;
    logic               capture;

    assign valid   = {req1_valid, req0_valid};
    assign take    = (state == IDLE) && any_valid;
    assign capture = (state == DATA) && bus.hready;

    ahb_arb_pick u_pick (
        .clk       (clk),
        .rstn      (rstn),
        .valid     (valid),
        .advance   (state == RESP),
        .grant     (grant),
        .win       (win),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            grant     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Request fields are frozen from arbitration until the RESP cycle ends.
            if (take) begin
                grant     <= win;
                lat_write <= win ? req1_write : req0_write;
                lat_addr  <= win ? req1_addr  : req0_addr;
                lat_wdata <= win ? req1_wdata : req0_wdata;
            end
            if (capture) begin
                rsp_rdata <= lat_write ? '0 : bus.hrdata;
                rsp_err   <= bus.hresp;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.hsel      = 1'b0;
        bus.hwrite    = 1'b0;
        bus.haddr_m2s = '0;
        bus.hdata_m2s = '0;
        req0_done     = 1'b0;
        req1_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus.hsel      = 1'b1;
                bus.hwrite    = lat_write;
                bus.haddr_m2s = lat_addr;
                state_nxt     = DATA;
            end
            DATA: begin
                if (lat_write) begin
                    bus.hdata_m2s = lat_wdata;
                end
                if (bus.hready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                req0_done = ~grant;
                req1_done = grant;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scoreboard bench for ahb_arbiter; follows AHB_ARB_RR_EN for grant order.
module tb_ahb_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0_valid, req0_write, req0_done;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_write, req1_done;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    ahb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ahb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef AHB_ARB_RR_EN
    int exp_g [5] = '{0, 1, 0, 1, 0};
`else
    int exp_g [5] = '{0, 0, 0, 0, 1};
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hsel"},   bus.hsel,      0);
        check({tag, "_hwrite"}, bus.hwrite,    0);
        check({tag, "_haddr"},  bus.haddr_m2s, 0);
        check({tag, "_hdata"},  bus.hdata_m2s, 0);
        check({tag, "_done0"},  req0_done,     0);
        check({tag, "_done1"},  req1_done,     0);
        check({tag, "_rdata"},  rsp_rdata,     0);
        check({tag, "_err"},    rsp_err,       0);
    endtask

    // Returns the index of the first done seen and the edges counted; idx=-1 on timeout.
    task automatic wait_done(input int budget, output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        while (cycles < budget && idx < 0) begin
            step();
            cycles++;
            if (req0_done === 1'b1) idx = 0;
            else if (req1_done === 1'b1) idx = 1;
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && (req0_done === 1'b1 || req1_done === 1'b1)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", sb.size(), 1);
            end else begin
                got_e = sb.pop_front();
                check("sb_idx",    req1_done,             got_e.idx);
                check("sb_onehot", req0_done & req1_done, 0);
                check("sb_rdata",  rsp_rdata,             got_e.rdata);
                check("sb_err",    rsp_err,               got_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc;
        rstn       = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;

        #12;
        check_quiet("reset");
        step();
        rstn = 1'b1;
        step();
        check_quiet("idle_no_req");

        // Single read, zero wait states
        bus.hrdata = 32'hDEAD_BEEF;
        req0_write = 1'b0; req0_addr = 32'h100; req0_wdata = 32'h5555_5555;
        req0_valid = 1'b1;
        sb.push_back('{idx: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        step();
        check("rd_addr_hsel",   bus.hsel,      1);
        check("rd_addr_haddr",  bus.haddr_m2s, 32'h100);
        check("rd_addr_hwrite", bus.hwrite,    0);
        step();
        check("rd_data_hsel",   bus.hsel,      0);
        check("rd_data_haddr",  bus.haddr_m2s, 0);
        check("rd_data_hdata",  bus.hdata_m2s, 0);
        check("rd_data_done0",  req0_done,     0);
        step();
        check("rd_done0",       req0_done,     1);
        check("rd_done1",       req1_done,     0);
        check("rd_rdata",       rsp_rdata,     32'hDEAD_BEEF);
        check("rd_err",         rsp_err,       0);
        req0_valid = 1'b0;
        step();
        check("rd_done_single", req0_done,     0);

        // Write from req1 with three wait states
        bus.hready = 1'b0; bus.hrdata = 32'h0BAD_F00D;
        req1_write = 1'b1; req1_addr = 32'h204; req1_wdata = 32'h1234_5678;
        req1_valid = 1'b1;
        sb.push_back('{idx: 1'b1, rdata: '0, err: 1'b0});
        step();
        check("wr_addr_hsel",   bus.hsel,      1);
        check("wr_addr_hwrite", bus.hwrite,    1);
        check("wr_addr_haddr",  bus.haddr_m2s, 32'h204);
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr_data_hdata", bus.hdata_m2s, 32'h1234_5678);
            check("wr_data_hsel",  bus.hsel,      0);
            check("wr_data_done1", req1_done,     0);
        end
        bus.hready = 1'b1;
        step();
        check("wr_done1",       req1_done,     1);
        check("wr_done0",       req0_done,     0);
        check("wr_rdata_zero",  rsp_rdata,     0);
        req1_valid = 1'b0;
        step();

        // Both requesters contending
        bus.hrdata = 32'hCAFE_0001;
        req0_write = 1'b0; req0_addr = 32'h300;
        req1_write = 1'b1; req1_addr = 32'h304; req1_wdata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{idx: exp_g[i][0], rdata: (exp_g[i] == 1) ? 32'h0 : 32'hCAFE_0001, err: 1'b0});
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_done(12, idx, cyc);
            check("arb_grant",   idx, exp_g[i]);
            check("arb_latency", cyc, (i == 0) ? 3 : 4);
            if (i == 3) begin
                if (exp_g[3] == 0) req0_valid = 1'b0;
                else req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Error response followed by a clean transfer
        bus.hresp = 1'b1; bus.hrdata = 32'h1111_2222;
        req0_write = 1'b0; req0_addr = 32'h400;
        req0_valid = 1'b1;
        sb.push_back('{idx: 1'b0, rdata: 32'h1111_2222, err: 1'b1});
        wait_done(12, idx, cyc);
        check("err_idx",     idx,     0);
        check("err_latency", cyc,     3);
        check("err_flag",    rsp_err, 1);
        req0_valid = 1'b0;
        bus.hresp  = 1'b0; bus.hrdata = 32'h3333_4444;
        step();
        req0_valid = 1'b1;
        sb.push_back('{idx: 1'b0, rdata: 32'h3333_4444, err: 1'b0});
        wait_done(12, idx, cyc);
        check("ok_idx",     idx,     0);
        check("ok_latency", cyc,     3);
        check("ok_err",     rsp_err, 0);
        req0_valid = 1'b0;
        step();

        // Reset during DATA aborts; held request completes afterwards
        bus.hready = 1'b0; bus.hrdata = 32'h5A5A_5A5A;
        req1_write = 1'b0; req1_addr = 32'h500;
        req1_valid = 1'b1;
        sb.push_back('{idx: 1'b1, rdata: 32'h5A5A_5A5A, err: 1'b0});
        step();
        check("rst_addr_hsel", bus.hsel, 1);
        step();
        check("rst_data_hsel", bus.hsel, 0);
        rstn = 1'b0;
        #1;
        check_quiet("rst_mid_data");
        bus.hready = 1'b1;
        step();
        check_quiet("rst_held_a");
        step();
        check_quiet("rst_held_b");
        rstn = 1'b1;
        wait_done(12, idx, cyc);
        check("rst_retry_idx",     idx, 1);
        check("rst_retry_latency", cyc, 3);
        req1_valid = 1'b0;
        step();
        step();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter AW, default `AHB_ADDR_WIDTH: address width.
REQ-002 Parameter DW, default `AHB_DATA_WIDTH: data width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid  in  1  request N (N=0,1) pending; held high until reqN_done.
REQ-005 reqN_write  in  1  request N is a write; stable while valid.
REQ-006 reqN_addr  in  AW  request N address; stable while valid.
REQ-007 reqN_wdata  in  DW  request N write data; stable while valid.
REQ-008 reqN_done  out  1  one-cycle completion pulse to requester N.
REQ-009 rsp_rdata  out  DW  read data, valid while any done is high.
REQ-010 rsp_err  out  1  latched hresp, valid while any done is high.
REQ-011 hsel / hwrite  out  1 / 1  slave select and direction, address phase.
REQ-012 haddr_m2s  out  AW  address, address phase.
REQ-013 hdata_m2s  out  DW  write data, data phase.
REQ-014 hready / hresp  in  1 / 1  slave ready and error.
REQ-015 hrdata  in  DW  slave read data.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA and RESP, and SHALL make exactly one transfer at a time.
REQ-017 In IDLE, if any valid is high, the arbiter SHALL pick a winner, latch its write/addr/wdata and grant index, and go to ADDR next cycle; otherwise it SHALL stay in IDLE.
REQ-018 In ADDR (exactly one cycle), hsel=1, hwrite=latched write and haddr_m2s=latched addr; the FSM SHALL then go to DATA.
REQ-019 In DATA, hsel=0, and hdata_m2s SHALL equal the latched wdata when write=1, else 0.
REQ-020 In DATA, the FSM SHALL wait while hready=0 (unbounded) and go to RESP on the first cycle with hready=1, capturing hrdata into rsp_rdata and hresp into rsp_err in that cycle.
REQ-021 In RESP (one cycle), the done of the granted requester SHALL be high, the other done low, and the FSM SHALL return to IDLE.
REQ-022 For a write, rsp_rdata SHALL be 0.
REQ-023 Minimum latency SHALL be: valid sampled at cycle T, ADDR at T+1, DATA at T+2, done at T+3; each hready=0 cycle adds one cycle.
REQ-024 Valid inputs SHALL NOT be sampled in ADDR, DATA or RESP; a requester drops valid in its done cycle, and the next arbitration occurs at the earliest in the following IDLE.
REQ-025 A request arriving while another is in flight SHALL wait and SHALL NOT be lost.
REQ-026 Outside ADDR, hsel, hwrite and haddr_m2s SHALL be 0.
REQ-027 Latched request fields SHALL NOT change between IDLE exit and RESP exit.

Reset
REQ-028 While rstn=0: state=IDLE, all outputs=0, latches=0, and the RR pointer favours req0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no done pulse; after release, the arbiter SHALL re-arbitrate from IDLE.

Configuration
REQ-030 Without AHB_ARB_RR_EN, arbitration SHALL be fixed priority, with req0 beating req1.
REQ-031 With AHB_ARB_RR_EN defined, a one-bit pointer SHALL update on each RESP to favour the non-granted requester; on tie the favoured requester wins, and a lone request always wins.

Structure
REQ-032 Shared package ahb_pkg SHALL hold the arb_state_e enum (IDLE/ADDR/DATA/RESP) and the NUM_REQ=2 constant; widths come from const_defines.svh.
REQ-033 One sub-module, ahb_arb_pick, SHALL hold the combinational winner select (fixed or RR) and the pointer register.

Verification
REQ-034 A single req0 read at addr 0x100 with hready=1 and hrdata=0xDEADBEEF -> haddr_m2s=0x100 at T+1, req0_done at T+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 A req1 write of 0x12345678 with hready low for 3 DATA cycles -> hdata_m2s=0x12345678 throughout DATA, req1_done at T+6.
REQ-036 req0 and req1 both valid continuously for 4 transfers -> fixed mode grants 0,0,0,0; RR mode grants 0,1,0,1.
REQ-037 hresp=1 with hready=1 in DATA -> rsp_err=1 in the done cycle; the next transfer reports rsp_err=0.
REQ-038 rstn pulsed low during DATA -> no done, all outputs 0 and state IDLE; the held request completes normally after reset release.
